// File: rtl/myproject_mul_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : myproject_mul_share_sched
// Purpose  : Round-robin scheduler that time-multiplexes one external
//            7-bit unsigned x 16-bit signed multiplier among NUM_REQ
//            requesters. It registers each product together with the index
//            of the requester that produced it, behind a valid/ready
//            response port that supports backpressure.
// Ports    : ap_clk, ap_rst         - clock, async active-high reset
//            req_valid/ready/a/b    - per-requester operand handshake
//            mul_din0/1, mul_dout   - shared multiplier operands / product
//            rsp_valid/ready/id/data- registered response port
//            issue_cnt              - wrapping count of accepted requests
// Revision : 1.0 - initial release
// ============================================================================
module myproject_mul_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*7-1:0]  req_a,
    input  logic [NUM_REQ*16-1:0] req_b,
    output logic [6:0]            mul_din0,
    output logic [15:0]           mul_din1,
    input  logic [22:0]           mul_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [22:0]           rsp_data,
    output logic [CNT_W-1:0]      issue_cnt
);

    // The candidate index can reach 2*NUM_REQ-1 before wrapping, so the
    // valid vector is padded to a width addressed exactly by ID_W+1 bits.
    localparam int c_PAD_W  = 2**(ID_W+1);
    localparam int c_LANE_N = 2**ID_W;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_rsp_id;
    logic [22:0]        r_rsp_data;
    logic [CNT_W-1:0]   r_issue_cnt;

    logic               w_can_issue;
    logic               w_grant_vld;
    logic [ID_W-1:0]    w_grant_id;
    logic [ID_W:0]      w_cand;
    logic [c_PAD_W-1:0] w_valid_pad;
    logic [c_LANE_N-1:0] w_ready_pad;
    logic [6:0]         w_a_lane [c_LANE_N];
    logic [15:0]        w_b_lane [c_LANE_N];

    // Unpack the flat operand buses into arrays indexed by requester id;
    // unused ids read as zero.
    for (genvar i = 0; i < c_LANE_N; i++) begin : g_lane
        if (i < NUM_REQ) begin : g_used
            assign w_a_lane[i] = req_a[7*i +: 7];
            assign w_b_lane[i] = req_b[16*i +: 16];
        end else begin : g_pad
            assign w_a_lane[i] = '0;
            assign w_b_lane[i] = '0;
        end
    end

    assign w_valid_pad = c_PAD_W'(req_valid);

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        w_can_issue = (r_state == ST_EMPTY) || rsp_ready;
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last_grant} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (ID_W+1)'(NUM_REQ);
            end
            if (!w_grant_vld && w_valid_pad[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_cand[ID_W-1:0];
            end
        end
        // No grant while reset is asserted keeps ready and operands at zero.
        if (!w_can_issue || ap_rst) begin
            w_grant_vld = 1'b0;
            w_grant_id  = '0;
        end
    end

    // Operands are forced to zero without a grant so the DSP does not toggle.
    always_comb begin
        w_ready_pad = '0;
        mul_din0    = '0;
        mul_din1    = '0;
        if (w_grant_vld) begin
            w_ready_pad[w_grant_id] = 1'b1;
            mul_din0                = w_a_lane[w_grant_id];
            mul_din1                = w_b_lane[w_grant_id];
        end
    end

    assign req_ready = w_ready_pad[NUM_REQ-1:0];

    // An accept always (re)fills the output register; otherwise a consumed
    // response empties it and an unconsumed one stays put.
    always_comb begin
        w_state_next = r_state;
        if (w_grant_vld) begin
            w_state_next = ST_FULL;
        end else if (rsp_ready) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state      <= ST_EMPTY;
            r_last_grant <= ID_W'(NUM_REQ-1);
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
            r_issue_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_vld) begin
                r_last_grant <= w_grant_id;
                r_rsp_id     <= w_grant_id;
                r_rsp_data   <= mul_dout;
                r_issue_cnt  <= r_issue_cnt + 1'b1;
            end
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign issue_cnt = r_issue_cnt;

endmodule
`default_nettype wire

// File: tb/tb_myproject_mul_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_myproject_mul_share_sched
// Purpose  : Self-checking bench for myproject_mul_share_sched. Models the
//            external multiplier, applies a vector table plus hand-written
//            backpressure / reset / counter-wrap sequences, and scores the
//            responses against an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_myproject_mul_share_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*7-1:0]  req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic [6:0]            mul_din0;
    logic [15:0]           mul_din1;
    logic [22:0]           mul_dout;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [22:0]           rsp_data;
    logic [CNT_W-1:0]      issue_cnt;

    myproject_mul_share_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .ap_clk    (clk),
        .ap_rst    (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .issue_cnt (issue_cnt)
    );

    // External shared multiplier: zero-latency {0,a} * signed b.
    assign mul_dout = $signed({1'b0, mul_din0}) * $signed(mul_din1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic [3:0] er;
        int         a;
        int         b;
    } vec_t;

    typedef struct {
        int id;
        int data;
    } exp_t;

    vec_t tbl[10];
    exp_t sbq[$];
    int   errors;
    int   checks;
    int   cnt_exp;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        cnt_exp = 0;
    endtask

    // Drive one cycle of stimulus (called 1 time unit after a rising edge).
    // The lane expected to be granted carries (a,b); the others carry
    // distinct filler so a wrong operand mux is visible.
    task automatic apply(input logic [3:0] v, input logic [3:0] er,
                         input int a, input int b, input logic rr);
        int   g;
        int   al;
        int   bl;
        exp_t e;
        g = -1;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (er[j]) g = j;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            al = (j == g) ? a : ((a + 9*j + 3) & 127);
            bl = (j == g) ? b : (b ^ (j*4099 + 7));
            req_a[7*j +: 7]   = al[6:0];
            req_b[16*j +: 16] = bl[15:0];
        end
        req_valid = v;
        rsp_ready = rr;
        #1;
        chk("req_ready", int'(req_ready), int'(er));
        if (g >= 0) begin
            chk("mul_din0", int'(mul_din0), a);
            chk("mul_din1", int'($signed(mul_din1)), b);
            e.id   = g;
            e.data = a * b;
            sbq.push_back(e);
            cnt_exp = (cnt_exp + 1) % (2**CNT_W);
        end else begin
            chk("mul_din0_idle", int'(mul_din0), 0);
            chk("mul_din1_idle", int'(mul_din1), 0);
        end
        if (rsp_valid && rr) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got response id %0d with nothing expected", rsp_id);
            end else begin
                e = sbq.pop_front();
                chk("rsp_id", int'(rsp_id), e.id);
                chk("rsp_data", int'($signed(rsp_data)), e.data);
            end
        end
        @(posedge clk);
        #1;
        chk("issue_cnt", int'(issue_cnt), cnt_exp);
        if (g >= 0) begin
            chk("rsp_valid_set", int'(rsp_valid), 1);
        end else if (rr) begin
            chk("rsp_valid_clr", int'(rsp_valid), 0);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cnt_exp   = 0;
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '1;
        req_b     = '1;
        rsp_ready = 1'b1;

        // Round-robin pointer starts at 3, so the search order begins at 0.
        tbl[0] = '{4'b0100, 4'b0100,   5,     -3};
        tbl[1] = '{4'b1111, 4'b1000, 127, -32768};
        tbl[2] = '{4'b0011, 4'b0001, 127,  32767};
        tbl[3] = '{4'b0011, 4'b0010,   0,     -1};
        tbl[4] = '{4'b0000, 4'b0000,   0,      0};
        tbl[5] = '{4'b0001, 4'b0001, 100,   1234};
        tbl[6] = '{4'b1001, 4'b1000,   3,     -7};
        tbl[7] = '{4'b1001, 4'b0001,  64,    500};
        tbl[8] = '{4'b0110, 4'b0010,   1, -32768};
        tbl[9] = '{4'b0101, 4'b0100,  77, -12345};

        // Reset state, with requests pending.
        #2;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_mul_din0", int'(mul_din0), 0);
        chk("rst_mul_din1", int'(mul_din1), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_issue_cnt", int'(issue_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors: single requests, extremes, rotation, idle cycle.
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].v, tbl[i].er, tbl[i].a, tbl[i].b, 1'b1);
        end
        apply(4'b0000, 4'b0000, 0, 0, 1'b1);

        // All requesters continuously valid: grants rotate 0,1,2,3,...
        do_reset();
        for (int k = 0; k < 8; k++) begin
            apply(4'b1111, 4'(1 << (k % 4)), 10 + k, -200 * k - 1, 1'b1);
        end
        chk("fair_issue_cnt", int'(issue_cnt), 8);

        // Backpressure: output full with requester 3's product.
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b1111;
            rsp_ready = 1'b0;
            #1;
            chk("bp_req_ready", int'(req_ready), 0);
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_id", int'(rsp_id), sbq[0].id);
            chk("bp_rsp_data", int'($signed(rsp_data)), sbq[0].data);
            @(posedge clk);
            #1;
        end
        // Drain and next grant (requester 0) on the same edge.
        apply(4'b1111, 4'b0001, 99, 321, 1'b1);
        chk("drain_grant_id", int'(rsp_id), 0);

        // Async reset between edges while a response is held.
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rsp_valid", int'(rsp_valid), 0);
        chk("arst_issue_cnt", int'(issue_cnt), 0);
        chk("arst_req_ready", int'(req_ready), 0);
        chk("arst_mul_din0", int'(mul_din0), 0);
        sbq.delete();
        cnt_exp = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(4'b0110, 4'b0010, 42, -42, 1'b1);
        apply(4'b0000, 4'b0000, 0, 0, 1'b1);

        // Counter wrap with a 4-bit counter.
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            apply(4'b0001, 4'b0001, k, -k, 1'b1);
            if (k == 15) chk("wrap_15", int'(issue_cnt), 15);
            if (k == 16) chk("wrap_16", int'(issue_cnt), 0);
            if (k == 17) chk("wrap_17", int'(issue_cnt), 1);
        end
        apply(4'b0000, 4'b0000, 0, 0, 1'b1);
        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/myproject_mul_share_sched.md
Name: myproject_mul_share_sched

Overview:
- Time-multiplexes one shared 7-bit-unsigned x 16-bit-signed multiplier (23-bit signed product, combinational, zero latency) among NUM_REQ requesters, e.g. parallel dense-layer lanes that would otherwise each own a DSP.
- Does round-robin arbitration, drives the shared multiplier operands, and registers each product tagged with the requester index.
- Has a valid/ready response port with backpressure.
- Sits between the layer lane logic and the multiplier instance, which is external to this block.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of requester index; 2**ID_W >= NUM_REQ.
- CNT_W, 16, width of the issue-statistics counter.

Ports:
- ap_clk  in  1  clock, all state on the rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*7  unsigned multiplicand; requester i uses bits [7i+6:7i].
- req_b  in  NUM_REQ*16  signed multiplier; requester i uses bits [16i+15:16i].
- mul_din0  out  7  operand A to the shared multiplier.
- mul_din1  out  16  operand B to the shared multiplier.
- mul_dout  in  23  signed product from the shared multiplier, same cycle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that produced rsp_data.
- rsp_data  out  23  signed product.
- issue_cnt  out  CNT_W  count of accepted requests, wraps.

Behaviour:
- Reset (async assert, any cycle including mid-transfer) forces:
  - rsp_valid=0, rsp_id=0, rsp_data=0, issue_cnt=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0 and mul_din0/mul_din1=0 during reset.
- Any in-flight response is discarded on reset; no partial outputs.
- Output register states:
  - EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
  - can_issue = !rsp_valid || rsp_ready.
- Arbitration (combinational each cycle):
  - If can_issue, grant the first i with req_valid[i]=1, searching from last_grant+1 upward and wrapping modulo NUM_REQ.
  - If there is no valid requester or can_issue=0, there is no grant.
- req_ready[g]=1 only for the granted g; all other bits are 0. req_ready does not depend on req_valid of the same requester beyond grant selection.
- Operand mux:
  - With a grant: mul_din0=req_a[g], mul_din1=req_b[g].
  - With no grant: both are driven to 0, to avoid DSP toggling.
- Accept = grant this cycle (req_valid[g] && req_ready[g]). On accept, at the next edge:
  - rsp_data <= mul_dout.
  - rsp_id <= g.
  - rsp_valid <= 1.
  - last_grant <= g.
  - issue_cnt <= issue_cnt+1, wrapping 2**CNT_W-1 -> 0.
- No accept and rsp_valid && rsp_ready: rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- No accept and rsp_valid && !rsp_ready: all response outputs hold, stable while valid.
- Simultaneous drain and accept (FULL, rsp_ready=1, grant present): the new product replaces the old one in the same edge. Throughput is 1 result/cycle.
- Latency: accept at cycle t -> rsp_valid=1 with the product in cycle t+1.
- last_grant changes only on accept; an idle cycle does not rotate priority.
- Arithmetic:
  - The product is {1'b0,a} * signed b, 23-bit signed, never overflows: range -4161536..4161409.
  - The block passes mul_dout unchanged; no sign/width manipulation.
- Fairness: with all NUM_REQ requesters continuously valid and rsp_ready=1, grants cycle 0,1,..,NUM_REQ-1,0,... Each requester waits at most NUM_REQ-1 accepted transfers.
- Requesters must hold req_valid/req_a/req_b until they see req_ready; the block does not check this.

Test Plan:
1. Reset then single request: req_valid=4'b0100, a=5, b=-3, rsp_ready=1 -> req_ready=4'b0100 in the same cycle, mul_din0=5, mul_din1=-3; next cycle rsp_valid=1, rsp_id=2, rsp_data=-15, issue_cnt=1.
2. Extremes: a=127, b=-32768 -> rsp_data=-4161536. Then a=127, b=32767 -> 4161409. a=0, b=-1 -> 0.
3. All four valid continuously, rsp_ready=1, 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 with one result per cycle and issue_cnt=8.
4. Backpressure: response FULL, rsp_ready=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0 throughout; rsp_data/rsp_id stable. When rsp_ready=1, the drain and the next grant (last_grant+1) happen on the same edge.
5. Async reset asserted mid-stream, between clock edges, while rsp_valid=1 -> rsp_valid, issue_cnt and req_ready go to 0 immediately. After release, the first grant goes to the lowest valid index.
6. issue_cnt wrap with CNT_W=4: 17 accepts -> issue_cnt reads 15 after the 15th accept, 0 after the 16th, and 1 after the 17th.
